// File: rtl/exp_arbiter.sv
// exp_arbiter
//   Round-robin arbiter sharing one exponential accelerator among N clients.
//   One request is accepted at a time. The winner's operand is latched onto
//   acc_x and acc_start is pulsed for one cycle. The arbiter then waits for
//   acc_done to fall and rise again, captures acc_result, and pulses
//   rsp_valid to the winner for one cycle.
//
//   Optional macro: EXP_ARB_TIMEOUT_EN
//     When defined, an 8-bit watchdog counts cycles spent in BUSY+WAIT.
//     On reaching TIMEOUT it forces a response with rsp_err=1 and
//     result_out=0.
//     When undefined, BUSY/WAIT wait indefinitely and rsp_err is tied to 0.
//
// Parameters
//   N        number of requesters (2..8)
//   XW       operand width
//   RW       result width
//   TIMEOUT  watchdog limit in cycles (1..255), used only with the macro
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   req         per-requester request level
//   x_in        operands; requester i uses [i*XW +: XW]
//   grant       one-hot, from the accept cycle through the response cycle
//   rsp_valid   one-cycle pulse to the winner
//   rsp_err     qualifies rsp_valid; 1 = watchdog abort
//   result_out  last captured result
//   acc_start   accelerator start (one-cycle pulse)
//   acc_x       latched operand driven to the accelerator
//   acc_done    accelerator done (high while the accelerator is idle)
//   acc_result  accelerator result
module exp_arbiter #(
  parameter int N       = 4,
  parameter int XW      = 16,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*XW-1:0]   x_in,
  output logic [N-1:0]      grant,
  output logic [N-1:0]      rsp_valid,
  output logic              rsp_err,
  output logic [RW-1:0]     result_out,
  output logic              acc_start,
  output logic [XW-1:0]     acc_x,
  input  logic              acc_done,
  input  logic [RW-1:0]     acc_result
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("exp_arbiter: N must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("exp_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   winner, winner_d;
  logic [N-1:0]    grant_d;
  logic [N-1:0]    rsp_valid_d;
  logic [RW-1:0]   result_d;
  logic            start_d;
  logic [XW-1:0]   acc_x_d;

  logic [PW-1:0]   pick;
  logic            found;
  logic [XW-1:0]   x_sel;

`ifdef EXP_ARB_TIMEOUT_EN
  logic [7:0]      wdog, wdog_d;
  logic            rsp_err_d;
`endif

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (PW'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin search: indices at or above ptr are scanned first, then the
  // wrapped-around indices below ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && PW'(j) >= ptr && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && PW'(j) < ptr && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  always_comb begin
    x_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (PW'(i) == pick) x_sel = x_in[i*XW +: XW];
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    winner_d    = winner;
    grant_d     = grant;
    rsp_valid_d = '0;
    result_d    = result_out;
    start_d     = 1'b0;
    acc_x_d     = acc_x;
`ifdef EXP_ARB_TIMEOUT_EN
    wdog_d      = wdog;
    rsp_err_d   = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (found && acc_done) begin
          state_d  = S_START;
          winner_d = pick;
          grant_d  = onehot(pick);
          acc_x_d  = x_sel;
          start_d  = 1'b1;
        end
      end
      S_START: begin
        state_d = S_BUSY;
`ifdef EXP_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_BUSY: begin
        if (!acc_done) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          state_d     = S_RESP;
          result_d    = acc_result;
          rsp_valid_d = onehot(winner);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef EXP_ARB_TIMEOUT_EN
    // Watchdog overrides BUSY/WAIT progress, except a normal completion
    // landing on the same cycle, which is reported as a good result.
    if (state == S_BUSY || state == S_WAIT) begin
      wdog_d = wdog + 8'd1;
      if (wdog == 8'(TIMEOUT - 1) && !(state == S_WAIT && acc_done)) begin
        state_d     = S_RESP;
        rsp_valid_d = onehot(winner);
        rsp_err_d   = 1'b1;
        result_d    = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      winner     <= '0;
      grant      <= '0;
      rsp_valid  <= '0;
      result_out <= '0;
      acc_start  <= 1'b0;
      acc_x      <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      winner     <= winner_d;
      grant      <= grant_d;
      rsp_valid  <= rsp_valid_d;
      result_out <= result_d;
      acc_start  <= start_d;
      acc_x      <= acc_x_d;
    end
  end

`ifdef EXP_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog    <= '0;
      rsp_err <= 1'b0;
    end else begin
      wdog    <= wdog_d;
      rsp_err <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
